preg_freelist: RTL and testbench
================================

Name: preg_freelist

Overview:
- Physical-register free-list controller for the rename stage.
- Hands out up to ALLOC_W free physical register ids per cycle to renaming instructions, with all-or-nothing allocation.
- Reclaims up to FREE_W ids per cycle from commit.
- Restores the speculative allocation pointer to the committed pointer on a pipeline flush.
- Sits between the RAT/rename logic and the ROB commit port.

Parameters:
- PREG_NUM, 64, number of physical registers; PREG_W = $clog2(PREG_NUM).
- AREG_NUM, 32, architectural registers; pregs 0..AREG_NUM-1 are mapped at reset and never on the list.
- ALLOC_W, 2, allocation slots per cycle (= FETCH_WIDTH).
- FREE_W, 2, free/commit slots per cycle (= COMMIT_WIDTH).
- DEPTH, PREG_NUM-AREG_NUM, list capacity (power of two required).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- alloc_req  in  ALLOC_W  per-slot request (instruction writes a dst)
- alloc_ready  out  1  every requested slot can be served this cycle
- alloc_id  out  ALLOC_W x PREG_W  id granted per slot (valid when requested and alloc_ready)
- free_valid  in  FREE_W  per-slot release of an old mapping at commit
- free_id  in  FREE_W x PREG_W  id being released
- commit_valid  in  FREE_W  per-slot commit of an instruction that allocated a preg
- flush  in  1  misprediction/exception recovery
- free_count  out  $clog2(DEPTH+1)  speculative free entries
- empty  out  1  free_count == 0

Behaviour:
- Storage: circular buffer of DEPTH PREG_W-bit entries.
- Pointers: head (speculative), commit_head, tail; each is $clog2(DEPTH)+1 bits, with the extra bit as wrap flag.
- Reset (resetn low, async):
  - entry i = AREG_NUM+i.
  - head = commit_head = 0; tail = DEPTH (wrap bit set, index 0).
  - free_count = DEPTH, empty = 0, alloc_ready = 1.
- Let n = popcount(alloc_req).
  - alloc_ready = (free_count >= n) && !flush; combinational.
  - n = 0 yields alloc_ready = 1.
- alloc_id: combinational, same cycle.
  - The k-th requesting slot, counted in ascending slot order, gets entry[(head+k) mod DEPTH].
  - Non-requesting slots output don't-care; drive the entry at head.
- Allocation fires when alloc_ready && n > 0: head += n at the next edge.
  - Partial allocation is forbidden: if not ready, head is unchanged and rename stalls.
- Free: each free_valid slot writes entry[tail + rank] in ascending slot order; tail += popcount(free_valid).
  - Frees are visible to allocation from the next cycle only; no same-cycle bypass.
- Commit: commit_head += popcount(commit_valid).
- free_count = tail - head, registered and updated every edge:
  - free_count_next = free_count + freed - (alloc fired ? n : 0).
- Flush, highest priority for head:
  - head_next = commit_head_next, i.e. commit_head including this cycle's commits.
  - Allocation is suppressed.
  - Frees and commits in the same cycle still apply.
  - free_count_next = tail_next - commit_head_next.
- Wrap-around: index = pointer[low bits]. full = indices equal and wrap bits differ.
- Overflow (free_count+freed > DEPTH) or commit_head passing head is a protocol error. Flag it with an assertion; no recovery logic.
- Simultaneous alloc + free at count 0: alloc is refused (ready=0), the free lands, and count becomes freed.

Decomposition:
- Shared package (rename_pkg) gains:
  - freelist_ptr_t
  - FREELIST_DEPTH
  - a freelist_alloc_t struct {valid; preg_addr_t id}
- One natural sub-module: prefix_rank, a combinational per-slot prefix popcount used for both alloc and free slot ordering. Instantiate it twice.

Test Plan:
- Reset, then alloc_req=2'b11 for one cycle -> alloc_id = {33,32} (slot1 = 33, slot0 = 32), alloc_ready = 1; next cycle free_count = 30.
- alloc_req=2'b10 only -> slot1 gets 32; next cycle alloc_req=2'b01 -> slot0 gets 33.
- Drain to free_count = 1, then alloc_req=2'b11 -> alloc_ready = 0, head unchanged; alloc_req=2'b01 -> ready = 1, id = 63, then empty = 1.
- From empty, free_valid=2'b11 with ids {5,7} and alloc_req=2'b01 in the same cycle -> ready = 0 that cycle; next cycle ready = 1, id = 5, then id = 7.
- Allocate 6 ids, commit_valid totals 2, then flush with free_valid=2'b01 -> head = commit_head = 2; free_count = (tail+1) - 2.
- Pointer wrap: 40 alloc/free round trips -> ids continue in FIFO order across index DEPTH-1 to 0; free_count never exceeds 32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions.
// Holds the physical/architectural register geometry, the free-list sizing
// and the pointer and grant types used by the physical-register free list.
package rename_pkg;

  localparam int PREG_NUM = 64;
  localparam int AREG_NUM = 32;
  localparam int ALLOC_W  = 2;
  localparam int FREE_W   = 2;
  localparam int PREG_W   = $clog2(PREG_NUM);

  localparam int FREELIST_DEPTH = PREG_NUM - AREG_NUM;
  localparam int FREELIST_IDX_W = $clog2(FREELIST_DEPTH);
  // One extra pointer bit acts as the wrap flag so full and empty differ.
  localparam int FREELIST_PTR_W = FREELIST_IDX_W + 1;
  localparam int FREELIST_CNT_W = $clog2(FREELIST_DEPTH + 1);

  typedef logic [PREG_W-1:0]         preg_addr_t;
  typedef logic [FREELIST_PTR_W-1:0] freelist_ptr_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
  } freelist_alloc_t;

  // Storage index of a wrap-flagged pointer.
  function automatic logic [FREELIST_IDX_W-1:0] ptr_idx(input freelist_ptr_t p);
    return p[FREELIST_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/prefix_rank.sv
// Per-slot exclusive prefix popcount.
// rank[i] is the number of set bits in vec[i-1:0], i.e. the position a
// requesting slot takes among the requesting slots in ascending order;
// total is popcount(vec).
// Ports:
//   vec   in  W           per-slot request bits
//   rank  out W x CNT_W   exclusive prefix count per slot
//   total out CNT_W       population count of vec
module prefix_rank #(
  parameter int W     = 2,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]            vec,
  output logic [W-1:0][CNT_W-1:0] rank,
  output logic [CNT_W-1:0]        total
);

  // Running sum: each slot sees the count of requesters below it.
  always_comb begin
    total = '0;
    rank  = '0;
    for (int i = 0; i < W; i++) begin
      rank[i] = total;
      total   = total + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list for the rename stage.
// A circular buffer of free preg ids. Rename takes up to ALLOC_W ids per
// cycle (all requested slots or none), commit returns up to FREE_W ids per
// cycle, and a flush rewinds the speculative head to the committed head so
// ids handed to squashed instructions become free again.
// Ports:
//   clk          in  clock
//   resetn       in  asynchronous active-low reset
//   alloc_req    in  ALLOC_W            per-slot allocation request
//   alloc_ready  out 1                  all requested slots can be served
//   alloc_id     out ALLOC_W x PREG_W   id granted per slot
//   free_valid   in  FREE_W             per-slot release of an old mapping
//   free_id      in  FREE_W x PREG_W    id being released
//   commit_valid in  FREE_W             per-slot commit of an allocating instr
//   flush        in  1                  misprediction/exception recovery
//   free_count   out CNT_W              speculative free entries
//   empty        out 1                  free_count == 0
module preg_freelist
  import rename_pkg::*;
(
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [ALLOC_W-1:0]                alloc_req,
  output logic                              alloc_ready,
  output logic [ALLOC_W-1:0][PREG_W-1:0]    alloc_id,
  input  logic [FREE_W-1:0]                 free_valid,
  input  logic [FREE_W-1:0][PREG_W-1:0]     free_id,
  input  logic [FREE_W-1:0]                 commit_valid,
  input  logic                              flush,
  output logic [FREELIST_CNT_W-1:0]         free_count,
  output logic                              empty
);

  localparam int A_CNT_W = $clog2(ALLOC_W + 1);
  localparam int F_CNT_W = $clog2(FREE_W + 1);

  logic [PREG_W-1:0] entries [FREELIST_DEPTH];

  freelist_ptr_t head, commit_head, tail;
  freelist_ptr_t head_next, commit_head_next, tail_next;
  logic [FREELIST_CNT_W-1:0] count_next;

  logic [ALLOC_W-1:0][A_CNT_W-1:0] alloc_rank;
  logic [A_CNT_W-1:0]              alloc_n;
  logic [FREE_W-1:0][F_CNT_W-1:0]  free_rank;
  logic [F_CNT_W-1:0]              free_n;
  logic [F_CNT_W-1:0]              commit_n;

  logic [FREELIST_IDX_W-1:0] alloc_idx [ALLOC_W];
  logic [FREELIST_IDX_W-1:0] free_idx  [FREE_W];

  logic alloc_fire;

  prefix_rank #(.W(ALLOC_W), .CNT_W(A_CNT_W)) u_alloc_rank (
    .vec   (alloc_req),
    .rank  (alloc_rank),
    .total (alloc_n)
  );

  prefix_rank #(.W(FREE_W), .CNT_W(F_CNT_W)) u_free_rank (
    .vec   (free_valid),
    .rank  (free_rank),
    .total (free_n)
  );

  always_comb begin
    commit_n = '0;
    for (int i = 0; i < FREE_W; i++) begin
      commit_n = commit_n + F_CNT_W'(commit_valid[i]);
    end
  end

  // Frees written this cycle only show up in free_count next cycle, so
  // allocation never sees them early.
  assign alloc_ready = (free_count >= FREELIST_CNT_W'(alloc_n)) && !flush;
  assign alloc_fire  = alloc_ready && (alloc_n != '0);
  assign empty       = (free_count == '0);

  // Non-requesting slots read the head entry (rank forced to zero).
  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_idx[i] = ptr_idx(head)
                   + FREELIST_IDX_W'(alloc_req[i] ? alloc_rank[i] : A_CNT_W'(0));
      alloc_id[i]  = entries[alloc_idx[i]];
    end
    for (int i = 0; i < FREE_W; i++) begin
      free_idx[i] = ptr_idx(tail) + FREELIST_IDX_W'(free_rank[i]);
    end
  end

  // Flush rewinds head to the committed head including this cycle's commits.
  always_comb begin
    commit_head_next = commit_head + freelist_ptr_t'(commit_n);
    tail_next        = tail + freelist_ptr_t'(free_n);
    head_next        = head;
    count_next       = free_count + FREELIST_CNT_W'(free_n);
    if (flush) begin
      head_next  = commit_head_next;
      count_next = FREELIST_CNT_W'(tail_next - commit_head_next);
    end else if (alloc_fire) begin
      head_next  = head + freelist_ptr_t'(alloc_n);
      count_next = free_count + FREELIST_CNT_W'(free_n) - FREELIST_CNT_W'(alloc_n);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= freelist_ptr_t'(FREELIST_DEPTH);
      free_count  <= FREELIST_CNT_W'(FREELIST_DEPTH);
    end else begin
      head        <= head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
      free_count  <= count_next;
    end
  end

  // Initially every non-architectural preg is free, in ascending order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FREELIST_DEPTH; i++) begin
        entries[i] <= PREG_W'(AREG_NUM + i);
      end
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (free_valid[i]) begin
          entries[free_idx[i]] <= free_id[i];
        end
      end
    end
  end

  // Protocol checks only; the list does not recover from these.
  logic [FREELIST_CNT_W:0] count_after_free;
  freelist_ptr_t           uncommitted;
  logic                    full;

  assign count_after_free = {1'b0, free_count} + (FREELIST_CNT_W + 1)'(free_n);
  assign uncommitted      = head - commit_head;
  assign full             = (ptr_idx(tail) == ptr_idx(head))
                         && (tail[FREELIST_IDX_W] != head[FREELIST_IDX_W]);

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    count_after_free <= (FREELIST_CNT_W + 1)'(FREELIST_DEPTH));

  a_commit_behind_head: assert property (@(posedge clk) disable iff (!resetn)
    freelist_ptr_t'(commit_n) <= uncommitted);

  a_full_matches_count: assert property (@(posedge clk) disable iff (!resetn)
    full == (free_count == FREELIST_CNT_W'(FREELIST_DEPTH)));

endmodule

// File: tb/tb_preg_freelist.sv
// Testbench for preg_freelist.
// Models the free list as two queues: ids free for allocation, and ids
// handed out but not yet committed. A flush puts the uncommitted ids back
// in front of the free queue. Directed sequences pin the model with literal
// values, then randomized traffic is checked against the model each cycle.
module tb_preg_freelist;
  import rename_pkg::*;

  logic                           clk = 1'b0;
  logic                           resetn;
  logic [ALLOC_W-1:0]             alloc_req;
  logic                           alloc_ready;
  logic [ALLOC_W-1:0][PREG_W-1:0] alloc_id;
  logic [FREE_W-1:0]              free_valid;
  logic [FREE_W-1:0][PREG_W-1:0]  free_id;
  logic [FREE_W-1:0]              commit_valid;
  logic                           flush;
  logic [FREELIST_CNT_W-1:0]      free_count;
  logic                           empty;

  int vectors     = 0;
  int miscompares = 0;

  int freeQ[$];
  int inflight[$];

  preg_freelist dut (
    .clk          (clk),
    .resetn       (resetn),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_id     (alloc_id),
    .free_valid   (free_valid),
    .free_id      (free_id),
    .commit_valid (commit_valid),
    .flush        (flush),
    .free_count   (free_count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  function automatic logic [1:0] limitBits(input logic [1:0] v, input int maxBits);
    logic [1:0] r;
    r = v;
    while ($countones(r) > maxBits) r = r & (r - 2'd1);
    return r;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input int f0,
                       input int f1, input logic [1:0] cv, input logic fl);
    alloc_req    = req;
    free_valid   = fv;
    free_id[0]   = PREG_W'(f0);
    free_id[1]   = PREG_W'(f1);
    commit_valid = cv;
    flush        = fl;
  endtask

  task automatic resetModel();
    freeQ.delete();
    inflight.delete();
    for (int i = 0; i < FREELIST_DEPTH; i++) freeQ.push_back(AREG_NUM + i);
  endtask

  task automatic applyReset();
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    resetn = 1'b0;
    resetModel();
    #12;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Compare all meaningful outputs against the queue model.
  task automatic checkOutput();
    int  n;
    int  k;
    bit  expReady;
    n        = $countones(alloc_req);
    expReady = (freeQ.size() >= n) && !flush;
    check("free_count", int'(free_count), freeQ.size());
    check("empty", int'(empty), int'(freeQ.size() == 0));
    check("alloc_ready", int'(alloc_ready), int'(expReady));
    if (expReady) begin
      k = 0;
      for (int i = 0; i < ALLOC_W; i++) begin
        if (alloc_req[i]) begin
          check($sformatf("alloc_id[%0d]", i), int'(alloc_id[i]), freeQ[k]);
          k++;
        end
      end
    end
  endtask

  task automatic updateModel();
    int n;
    bit ready;
    n     = $countones(alloc_req);
    ready = (freeQ.size() >= n) && !flush;
    for (int i = 0; i < $countones(commit_valid); i++) void'(inflight.pop_front());
    if (flush) begin
      for (int i = inflight.size() - 1; i >= 0; i--) freeQ.push_front(inflight[i]);
      inflight.delete();
    end else if (ready) begin
      for (int i = 0; i < n; i++) inflight.push_back(freeQ.pop_front());
    end
    for (int i = 0; i < FREE_W; i++) begin
      if (free_valid[i]) freeQ.push_back(int'(free_id[i]));
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] fv, input int f0,
                               input int f1, input logic [1:0] cv, input logic fl);
    drive(req, fv, f0, f1, cv, fl);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic endCycle();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] req, fv, cv;
    logic       fl;
    int         total;

    resetn = 1'b0;
    applyReset();

    // Reset state and first dual allocation.
    applyStimulus(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    check("reset free_count", int'(free_count), 32);
    check("reset empty", int'(empty), 0);
    check("reset alloc_ready", int'(alloc_ready), 1);
    endCycle();
    applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    check("dual ready", int'(alloc_ready), 1);
    check("dual slot0", int'(alloc_id[0]), 32);
    check("dual slot1", int'(alloc_id[1]), 33);
    endCycle();
    applyStimulus(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    check("count after dual", int'(free_count), 30);
    endCycle();

    // Single-slot requests take ids in ascending request order.
    applyReset();
    applyStimulus(2'b10, 2'b00, 0, 0, 2'b00, 1'b0);
    check("slot1 only id", int'(alloc_id[1]), 32);
    endCycle();
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    check("slot0 only id", int'(alloc_id[0]), 33);
    endCycle();

    // Drain to one entry; a two-slot request must stall as a whole.
    applyReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      endCycle();
    end
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    endCycle();
    applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    check("last one count", int'(free_count), 1);
    check("partial refused", int'(alloc_ready), 0);
    endCycle();
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    check("last ready", int'(alloc_ready), 1);
    check("last id", int'(alloc_id[0]), 63);
    endCycle();
    applyStimulus(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    check("now empty", int'(empty), 1);
    endCycle();

    // Free while empty: no same-cycle bypass, then FIFO order.
    applyStimulus(2'b01, 2'b11, 5, 7, 2'b11, 1'b0);
    check("empty free ready", int'(alloc_ready), 0);
    endCycle();
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    check("refill ready", int'(alloc_ready), 1);
    check("refill id 5", int'(alloc_id[0]), 5);
    endCycle();
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    check("refill id 7", int'(alloc_id[0]), 7);
    endCycle();

    // Allocate six, commit two, flush with one free in the same cycle.
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      endCycle();
    end
    applyStimulus(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
    endCycle();
    applyStimulus(2'b01, 2'b01, 9, 0, 2'b00, 1'b1);
    check("flush blocks alloc", int'(alloc_ready), 0);
    endCycle();
    applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    check("flush count", int'(free_count), 31);
    check("flush slot0", int'(alloc_id[0]), 34);
    check("flush slot1", int'(alloc_id[1]), 35);
    endCycle();

    // Round trips carry the pointers across the end of the buffer.
    applyReset();
    applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    endCycle();
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(2'b01, 2'b01, i, 0, 2'b01, 1'b0);
      check("wrap count bound", int'(free_count <= 6'd32), 1);
      endCycle();
    end

    // Randomized traffic within the protocol limits.
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      req   = 2'($urandom);
      fl    = ($urandom_range(0, 15) == 0);
      cv    = limitBits(2'($urandom), inflight.size());
      total = freeQ.size() + inflight.size() - $countones(cv);
      fv    = limitBits(2'($urandom), FREELIST_DEPTH - total);
      applyStimulus(req, fv, int'($urandom_range(0, PREG_NUM - 1)),
                    int'($urandom_range(0, PREG_NUM - 1)), cv, fl);
      endCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
